// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/response bundle of the nibble sequencer (rsp_zero exists with ALU_SEQ_ZERO_FLAG_EN)
interface alu_seq_ctrl_if #(parameter int NIBBLES = 4);
   localparam int W = 4 * NIBBLES;
   logic req_valid, req_ready, req_cin, req_shin;
   logic [3:0] req_op;
   logic [W-1:0] req_a, req_b;
   logic rsp_valid, rsp_ready, rsp_cout;
   logic [W-1:0] rsp_result;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic rsp_zero;
   modport master (output req_valid, req_op, req_a, req_b, req_cin, req_shin, rsp_ready,
                   input req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero);
   modport slave (input req_valid, req_op, req_a, req_b, req_cin, req_shin, rsp_ready,
                  output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero);
`else
   modport master (output req_valid, req_op, req_a, req_b, req_cin, req_shin, rsp_ready,
                   input req_ready, rsp_valid, rsp_result, rsp_cout);
   modport slave (input req_valid, req_op, req_a, req_b, req_cin, req_shin, rsp_ready,
                  output req_ready, rsp_valid, rsp_result, rsp_cout);
`endif
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: runs 4*NIBBLES-bit ops on a 4-bit ALU slice, one nibble per clock (optional rsp_zero via ALU_SEQ_ZERO_FLAG_EN)
module alu_seq_ctrl #(parameter int NIBBLES = 4) (
   input  logic clk,
   input  logic rst_n,
   alu_seq_ctrl_if.slave bus,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [3:0] alu_s,
   output logic alu_cin,
   output logic alu_al,
   output logic alu_ar,
   input  logic [3:0] alu_o,
   input  logic alu_cout
);
   localparam int W = 4 * NIBBLES;
   localparam int KW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [3:0] op;
   logic [W-1:0] a, b, result;
   logic c, shin, ready, valid, cout, run, last;
   logic [KW-1:0] k;
   logic [W:0] ar_v, al_v;
   assign run = state == RUN;
   assign last = k == KW'(NIBBLES - 1);
   // Fill bits: the shift-in bit sits below A for left shifts and above A for right shifts
   assign ar_v = {a, shin};
   assign al_v = {shin, a};
   assign alu_a = run ? a[4*k +: 4] : 4'h0;
   assign alu_b = run ? b[4*k +: 4] : 4'h0;
   assign alu_s = run ? op : 4'h0;
   assign alu_cin = run & c;
   assign alu_ar = run & ar_v[4*k];
   assign alu_al = run & al_v[4*k+4];
   assign bus.req_ready = ready;
   assign bus.rsp_valid = valid;
   assign bus.rsp_result = result;
   assign bus.rsp_cout = cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic zero;
   assign bus.rsp_zero = zero & valid;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ready <= 1'b1;
         valid <= 1'b0;
         cout <= 1'b0;
         result <= '0;
         op <= '0;
         a <= '0;
         b <= '0;
         c <= 1'b0;
         shin <= 1'b0;
         k <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
         zero <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.req_valid && ready) begin
               state <= RUN;
               ready <= 1'b0;
               op <= bus.req_op;
               a <= bus.req_a;
               b <= bus.req_b;
               c <= bus.req_cin;
               shin <= bus.req_shin;
               k <= '0;
               result <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
               zero <= 1'b1;
`endif
            end
            RUN: begin
               result[4*k +: 4] <= alu_o;
               c <= alu_cout;
               k <= last ? '0 : k + 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
               zero <= zero & ~|alu_o;
`endif
               if (last) begin
                  state <= DONE;
                  valid <= 1'b1;
                  cout <= op[3] ? (op[2] ? a[W-1] : a[0]) : (~op[2] & alu_cout);
               end
            end
            DONE: if (bus.rsp_ready) begin
               state <= IDLE;
               valid <= 1'b0;
               ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized and directed checks of alu_seq_ctrl against a wide-arithmetic reference model
module tb_alu_seq_ctrl;
   localparam int N = 4;
   localparam int W = 4 * N;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   alu_seq_ctrl_if #(.NIBBLES(N)) bus();
   logic [3:0] alu_a, alu_b, alu_s, alu_o, alu_bop, alu_lg;
   logic alu_cin, alu_al, alu_ar, alu_cout;
   logic [4:0] alu_sum;
   alu_seq_ctrl #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
      .alu_al(alu_al), .alu_ar(alu_ar), .alu_o(alu_o), .alu_cout(alu_cout)
   );
   // 4-bit ALU slice stand-in: arith (A+B, A-B, A+cin, A-1), logic (AND, OR, XOR, NOT A), shift right, shift left
   assign alu_bop = alu_s[1:0] == 2'd0 ? alu_b : alu_s[1:0] == 2'd1 ? ~alu_b : alu_s[1:0] == 2'd2 ? 4'h0 : 4'hF;
   assign alu_sum = {1'b0, alu_a} + {1'b0, alu_bop} + {4'b0, alu_cin};
   assign alu_lg = alu_s[1:0] == 2'd0 ? alu_a & alu_b : alu_s[1:0] == 2'd1 ? alu_a | alu_b :
                   alu_s[1:0] == 2'd2 ? alu_a ^ alu_b : ~alu_a;
   assign alu_o = alu_s[3:2] == 2'd0 ? alu_sum[3:0] : alu_s[3:2] == 2'd1 ? alu_lg :
                  alu_s[3:2] == 2'd2 ? {alu_al, alu_a[3:1]} : {alu_a[2:0], alu_ar};
   assign alu_cout = alu_s[3:2] == 2'd0 ? alu_sum[4] : alu_s[3:2] == 2'd1 ? 1'b0 :
                     alu_s[3:2] == 2'd2 ? alu_a[0] : alu_a[3];
   int pass_cnt = 0;
   int total = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [W:0] ref_op(input logic [3:0] op, input logic [W-1:0] a, b,
                                         input logic cin, shin);
      logic [W:0] s;
      logic [W-1:0] bo;
      case (op[3:2])
         2'd0: begin
            bo = op[1:0] == 2'd0 ? b : op[1:0] == 2'd1 ? ~b : op[1:0] == 2'd2 ? '0 : '1;
            s = {1'b0, a} + {1'b0, bo} + W'(cin);
            return s;
         end
         2'd1: return {1'b0, op[1:0] == 2'd0 ? a & b : op[1:0] == 2'd1 ? a | b : op[1:0] == 2'd2 ? a ^ b : ~a};
         2'd2: return {a[0], shin, a[W-1:1]};
         default: return {a[W-1], a[W-2:0], shin};
      endcase
   endfunction
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, b, input logic cin, shin);
      int n = 0;
      while (!bus.req_ready && n < 20) begin step(); n++; end
      bus.req_op = op;
      bus.req_a = a;
      bus.req_b = b;
      bus.req_cin = cin;
      bus.req_shin = shin;
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      check("accept", bus.req_ready, 0);
   endtask
   task automatic wait_rsp(input logic [W-1:0] er, input logic ec, input int hold);
      int cyc = 1;
      while (!bus.rsp_valid && cyc < 50) begin step(); cyc++; end
      check("latency", cyc, N + 1);
      check("result", bus.rsp_result, er);
      check("cout", bus.rsp_cout, ec);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      check("zero", bus.rsp_zero, er == 0);
`endif
      for (int i = 0; i < hold; i++) begin
         step();
         check("hold_result", bus.rsp_result, er);
         check("hold_cout", bus.rsp_cout, ec);
         check("hold_valid", bus.rsp_valid, 1);
         check("hold_ready", bus.req_ready, 0);
      end
   endtask
   task automatic finish_rsp();
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      check("rsp_done", bus.rsp_valid, 0);
      check("idle_ready", bus.req_ready, 1);
      check("alu_idle", {alu_a, alu_b, alu_s, alu_cin, alu_al, alu_ar}, 0);
   endtask
   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, b, input logic cin, shin,
                        input logic [W-1:0] er, input logic ec, input int hold);
      send(op, a, b, cin, shin);
      wait_rsp(er, ec, hold);
      finish_rsp();
   endtask
   initial begin
      logic [W:0] r;
      logic [3:0] op;
      logic [W-1:0] a, b;
      logic cin, shin;
      bus.req_valid = 1'b0;
      bus.req_op = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_cin = 1'b0;
      bus.req_shin = 1'b0;
      bus.rsp_ready = 1'b0;
      repeat (3) step();
      check("rst_ready", bus.req_ready, 1);
      check("rst_valid", bus.rsp_valid, 0);
      check("rst_result", bus.rsp_result, 0);
      check("rst_alu", {alu_a, alu_b, alu_s, alu_cin, alu_al, alu_ar}, 0);
      rst_n = 1'b1;
      step();
      do_op(4'b0000, 16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, 0);
      do_op(4'b0001, 16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0);
      do_op(4'b0001, 16'h0007, 16'h0005, 1, 0, 16'h0002, 1, 1);
      do_op(4'b0011, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 0, 0);
      do_op(4'b1100, 16'h8001, 16'h0000, 0, 1, 16'h0003, 1, 0);
      do_op(4'b1000, 16'h8001, 16'h0000, 0, 0, 16'h4000, 1, 0);
      do_op(4'b0110, 16'hF0F0, 16'hFF00, 0, 0, 16'h0FF0, 0, 0);
      do_op(4'b0110, 16'h5A5A, 16'h5A5A, 0, 0, 16'h0000, 0, 0);
      // Backpressure with a new request waiting upstream
      send(4'b0110, 16'hF0F0, 16'hFF00, 0, 0);
      wait_rsp(16'h0FF0, 0, 0);
      bus.req_op = 4'b0000;
      bus.req_a = 16'h0001;
      bus.req_b = 16'h0001;
      bus.req_cin = 1'b0;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_result", bus.rsp_result, 16'h0FF0);
         check("bp_cout", bus.rsp_cout, 0);
         check("bp_ready", bus.req_ready, 0);
         check("bp_not_taken", alu_a, 0);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      check("bp_rsp_done", bus.rsp_valid, 0);
      check("bp_wait_one", bus.req_ready, 1);
      step();
      bus.req_valid = 1'b0;
      check("bp_taken", bus.req_ready, 0);
      wait_rsp(16'h0002, 0, 0);
      finish_rsp();
      // Asynchronous reset during nibble 2
      send(4'b0000, 16'h1111, 16'h1111, 0, 0);
      step();
      step();
      check("run_k2", alu_a, 4'h1);
      check("run_partial", bus.rsp_result, 16'h0022);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_ready", bus.req_ready, 1);
      check("mid_rst_valid", bus.rsp_valid, 0);
      check("mid_rst_result", bus.rsp_result, 0);
      check("mid_rst_cout", bus.rsp_cout, 0);
      check("mid_rst_alu", {alu_a, alu_b, alu_s, alu_cin, alu_al, alu_ar}, 0);
      step();
      rst_n = 1'b1;
      step();
      do_op(4'b0000, 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0);
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom);
         a = W'($urandom);
         b = W'($urandom);
         cin = 1'($urandom);
         shin = 1'($urandom);
         r = ref_op(op, a, b, cin, shin);
         do_op(op, a, b, cin, shin, r[W-1:0], r[W], $urandom_range(0, 2));
      end
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
